// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the memory arbiter slice.
//   word_t      : 32-bit machine word
//   ramstate_t  : RAM handshake state (FREE, BUSY, ACCESS, ERROR)
//   arb_state_t : mem_request_arbiter FSM states (IDLE, DATA, INSTR, FAULT)
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    INSTR = 2'd2,
    FAULT = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Per-transaction wait-state and retry counters for mem_request_arbiter.
// Ports:
//   CLK, nRST   : clock, synchronous active-low reset
//   clr         : clear both counters
//   wait_inc    : one more FREE/BUSY cycle in the current attempt
//   retry_inc   : an ERROR response; bumps retry and restarts the wait count
//   wait_last   : this is the final tolerated FREE/BUSY cycle (wait == WAIT_MAX-1)
//   retry_last  : an ERROR now reaches RETRY_MAX
module mem_wait_timer #(
  parameter int unsigned WAIT_MAX  = 64,
  parameter int unsigned RETRY_MAX = 3
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clr,
  input  logic wait_inc,
  input  logic retry_inc,
  output logic wait_last,
  output logic retry_last
);

  localparam int unsigned WAIT_W  = (WAIT_MAX  > 1) ? $clog2(WAIT_MAX)  : 1;
  localparam int unsigned RETRY_W = (RETRY_MAX > 1) ? $clog2(RETRY_MAX) : 1;

  logic [WAIT_W-1:0]  wait_q,  wait_d;
  logic [RETRY_W-1:0] retry_q, retry_d;

  always_comb begin
    wait_d  = wait_q;
    retry_d = retry_q;
    if (clr) begin
      wait_d  = '0;
      retry_d = '0;
    end else if (retry_inc) begin
      retry_d = retry_q + RETRY_W'(1);
      wait_d  = '0;
    end else if (wait_inc) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wait_q  <= '0;
      retry_q <= '0;
    end else begin
      wait_q  <= wait_d;
      retry_q <= retry_d;
    end
  end

  // Compared before the increment: the counter only ever holds values below its limit.
  assign wait_last  = (wait_q  == WAIT_W'(WAIT_MAX - 1));
  assign retry_last = (retry_q == RETRY_W'(RETRY_MAX - 1));

endmodule

// File: rtl/mem_request_arbiter.sv
// Serializes instruction fetches and data loads/stores onto one single-port RAM.
// Data requests win over fetches; no preemption of a fetch in progress.
// ihit/dhit pulse combinationally in the RAM ACCESS cycle. Bounded retry on
// ERROR and bounded wait on FREE/BUSY; either limit enters a sticky FAULT.
// Optional feature macro: MEM_ARB_IBUF_EN (one-entry fetch buffer).
// Ports:
//   CLK, nRST                  : clock, synchronous active-low reset
//   imemREN, imemaddr          : fetch request / address
//   dmemREN, dmemWEN           : data load / store request
//   dmemaddr, dmemstore        : data address / store data
//   ihit, imemload             : fetch complete pulse / instruction
//   dhit, dmemload             : data complete pulse / load data
//   memfault                   : sticky fault flag
//   ramREN, ramWEN             : RAM strobes
//   ramaddr, ramstore, ramload : RAM address / write data / read data
//   ramstate                   : RAM handshake (FREE, BUSY, ACCESS, ERROR)
module mem_request_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned RETRY_MAX = 3,
  parameter int unsigned WAIT_MAX  = 64
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        memfault,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  arb_state_t state_q, state_d;
  ramstate_t  rs;
  logic       dreq;
  logic       tmr_clr, wait_inc, retry_inc;
  logic       wait_last, retry_last;

  assign rs   = ramstate_t'(ramstate);
  assign dreq = dmemREN | dmemWEN;

  mem_wait_timer #(
    .WAIT_MAX  (WAIT_MAX),
    .RETRY_MAX (RETRY_MAX)
  ) u_timer (
    .CLK        (CLK),
    .nRST       (nRST),
    .clr        (tmr_clr),
    .wait_inc   (wait_inc),
    .retry_inc  (retry_inc),
    .wait_last  (wait_last),
    .retry_last (retry_last)
  );

`ifdef MEM_ARB_IBUF_EN
  logic  ibuf_valid_q, ibuf_valid_d;
  word_t ibuf_addr_q,  ibuf_addr_d;
  word_t ibuf_data_q,  ibuf_data_d;
  logic  ibuf_hit;

  assign ibuf_hit = ibuf_valid_q && (imemaddr == ibuf_addr_q);

  always_comb begin
    ibuf_valid_d = ibuf_valid_q;
    ibuf_addr_d  = ibuf_addr_q;
    ibuf_data_d  = ibuf_data_q;
    if (ihit) begin
      ibuf_valid_d = 1'b1;
      ibuf_addr_d  = imemaddr;
      ibuf_data_d  = imemload;
    end else if (dhit && dmemWEN && (dmemaddr == ibuf_addr_q)) begin
      ibuf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      ibuf_valid_q <= 1'b0;
      ibuf_addr_q  <= '0;
      ibuf_data_q  <= '0;
    end else begin
      ibuf_valid_q <= ibuf_valid_d;
      ibuf_addr_q  <= ibuf_addr_d;
      ibuf_data_q  <= ibuf_data_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    ihit      = 1'b0;
    dhit      = 1'b0;
    imemload  = '0;
    dmemload  = '0;
    memfault  = 1'b0;
    tmr_clr   = 1'b0;
    wait_inc  = 1'b0;
    retry_inc = 1'b0;

    unique case (state_q)
      IDLE: begin
        tmr_clr = 1'b1;
        if (dreq) begin
          state_d = DATA;
        end else if (imemREN) begin
`ifdef MEM_ARB_IBUF_EN
          if (ibuf_hit) begin
            ihit     = 1'b1;
            imemload = ibuf_data_q;
          end else
`endif
          state_d = INSTR;
        end
      end

      DATA: begin
        ramaddr  = dmemaddr;
        ramstore = dmemstore;
        ramWEN   = dmemWEN;
        ramREN   = dmemREN & ~dmemWEN;
        if (!dreq) begin
          state_d = IDLE;
          tmr_clr = 1'b1;
        end else begin
          unique case (rs)
            ACCESS: begin
              dhit     = 1'b1;
              dmemload = ramload;
              state_d  = IDLE;
              tmr_clr  = 1'b1;
            end
            ERROR: begin
              retry_inc = 1'b1;
              if (retry_last) state_d = FAULT;
            end
            default: begin
              wait_inc = 1'b1;
              if (wait_last) state_d = FAULT;
            end
          endcase
        end
      end

      INSTR: begin
        ramaddr = imemaddr;
        ramREN  = 1'b1;
        if (!imemREN) begin
          state_d = IDLE;
          tmr_clr = 1'b1;
        end else begin
          unique case (rs)
            ACCESS: begin
              ihit     = 1'b1;
              imemload = ramload;
              state_d  = IDLE;
              tmr_clr  = 1'b1;
            end
            ERROR: begin
              retry_inc = 1'b1;
              if (retry_last) state_d = FAULT;
            end
            default: begin
              wait_inc = 1'b1;
              if (wait_last) state_d = FAULT;
            end
          endcase
        end
      end

      FAULT: begin
        memfault = 1'b1;
        tmr_clr  = 1'b1;
      end

      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the state combinationally, so the reset cycle
    // masks them explicitly to keep every output low while nRST is asserted.
    if (!nRST) begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      ihit     = 1'b0;
      dhit     = 1'b0;
      imemload = '0;
      dmemload = '0;
      memfault = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

endmodule

// File: tb/tb_mem_request_arbiter.sv
module tb_mem_request_arbiter;

  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  logic        CLK, nRST;
  logic        imemREN, dmemREN, dmemWEN;
  logic [31:0] imemaddr, dmemaddr, dmemstore, ramload;
  logic [1:0]  ramstate;
  logic        ihit, dhit, memfault, ramREN, ramWEN;
  logic [31:0] imemload, dmemload, ramaddr, ramstore;

  int total = 0;
  int bad   = 0;

  mem_request_arbiter #(.RETRY_MAX(3), .WAIT_MAX(8)) dut (
    .CLK(CLK), .nRST(nRST),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .ihit(ihit), .imemload(imemload), .dhit(dhit), .dmemload(dmemload),
    .memfault(memfault), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // status = {ramREN, ramWEN, ihit, dhit, memfault}
  function automatic logic [4:0] st();
    return {ramREN, ramWEN, ihit, dhit, memfault};
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    imemREN = 0; dmemREN = 0; dmemWEN = 0;
    imemaddr = '0; dmemaddr = '0; dmemstore = '0;
    ramload = '0; ramstate = RS_FREE;
  endtask

  task automatic do_reset();
    nRST = 0; idle_inputs(); cyc(); cyc(); nRST = 1;
  endtask

  task automatic test_reset();
    nRST = 0;
    imemREN = 1; dmemWEN = 1; dmemREN = 1; ramstate = RS_ACCESS; ramload = 32'hFFFF_FFFF;
    dmemaddr = 32'h44; dmemstore = 32'h1234;
    cyc(); cyc(); smp();
    total++; if (st() !== 5'b00000) begin bad++; $display("FAIL reset_status got=%b exp=%b", st(), 5'b00000); end
    total++; if ({imemload, dmemload, ramaddr, ramstore} !== 128'h0) begin bad++;
      $display("FAIL reset_data got=%h/%h/%h/%h exp=0", imemload, dmemload, ramaddr, ramstore); end
    idle_inputs(); cyc(); nRST = 1; cyc(); smp();
    total++; if (st() !== 5'b00000) begin bad++; $display("FAIL post_reset_idle got=%b exp=%b", st(), 5'b00000); end
  endtask

  task automatic test_fetch_wait();
    idle_inputs(); cyc();
    imemREN = 1; imemaddr = 32'h0; ramstate = RS_BUSY; smp();           // cycle 1: IDLE
    total++; if (st() !== 5'b00000) begin bad++; $display("FAIL fetch_c1 got=%b exp=%b", st(), 5'b00000); end
    cyc(); smp();                                                       // cycle 2: INSTR BUSY
    total++; if (st() !== 5'b10000 || ramaddr !== 32'h0) begin bad++;
      $display("FAIL fetch_c2 got=%b/%h exp=%b/%h", st(), ramaddr, 5'b10000, 32'h0); end
    cyc(); smp();                                                       // cycle 3: INSTR BUSY
    total++; if (st() !== 5'b10000) begin bad++; $display("FAIL fetch_c3 got=%b exp=%b", st(), 5'b10000); end
    cyc(); ramstate = RS_ACCESS; ramload = 32'h3C01_0001; smp();        // cycle 4: ACCESS
    total++; if (st() !== 5'b10100) begin bad++; $display("FAIL fetch_c4_hit got=%b exp=%b", st(), 5'b10100); end
    total++; if (imemload !== 32'h3C01_0001) begin bad++;
      $display("FAIL fetch_c4_load got=%h exp=%h", imemload, 32'h3C01_0001); end
    cyc(); imemREN = 0; ramstate = RS_FREE; smp();                      // cycle 5: back in IDLE
    total++; if (st() !== 5'b00000 || imemload !== 32'h0) begin bad++;
      $display("FAIL fetch_c5_idle got=%b/%h exp=%b/0", st(), imemload, 5'b00000); end
  endtask

  task automatic test_priority();
    idle_inputs(); cyc();
    imemREN = 1; imemaddr = 32'h100; dmemREN = 1; dmemaddr = 32'h80; cyc();
    ramstate = RS_ACCESS; ramload = 32'h1111_2222; smp();               // DATA first
    total++; if (st() !== 5'b10010 || ramaddr !== 32'h80) begin bad++;
      $display("FAIL prio_data got=%b/%h exp=%b/%h", st(), ramaddr, 5'b10010, 32'h80); end
    total++; if (dmemload !== 32'h1111_2222) begin bad++;
      $display("FAIL prio_dload got=%h exp=%h", dmemload, 32'h1111_2222); end
    cyc(); dmemREN = 0; ramstate = RS_ACCESS; ramload = 32'h5555_0000; smp(); // bubble
    total++; if (st() !== 5'b00000) begin bad++; $display("FAIL prio_bubble got=%b exp=%b", st(), 5'b00000); end
    cyc(); smp();                                                       // INSTR
    total++; if (st() !== 5'b10100 || ramaddr !== 32'h100 || imemload !== 32'h5555_0000) begin bad++;
      $display("FAIL prio_instr got=%b/%h/%h exp=%b/%h/%h", st(), ramaddr, imemload, 5'b10100, 32'h100, 32'h5555_0000); end
    cyc(); imemREN = 0;
  endtask

  task automatic test_store();
    idle_inputs(); cyc();
    dmemWEN = 1; dmemREN = 1; dmemaddr = 32'h40; dmemstore = 32'hDEAD_BEEF; ramstate = RS_BUSY;
    cyc(); smp();
    total++; if (st() !== 5'b01000 || ramstore !== 32'hDEAD_BEEF || ramaddr !== 32'h40) begin bad++;
      $display("FAIL store_busy got=%b/%h/%h exp=%b/%h/%h", st(), ramstore, ramaddr, 5'b01000, 32'hDEAD_BEEF, 32'h40); end
    cyc(); ramstate = RS_ACCESS; smp();
    total++; if (st() !== 5'b01010) begin bad++; $display("FAIL store_hit got=%b exp=%b", st(), 5'b01010); end
    cyc(); dmemWEN = 0; dmemREN = 0; smp();
    total++; if (st() !== 5'b00000) begin bad++; $display("FAIL store_after got=%b exp=%b", st(), 5'b00000); end
  endtask

  task automatic test_no_preempt();
    idle_inputs(); cyc();
    imemREN = 1; imemaddr = 32'h200; ramstate = RS_BUSY; cyc();
    dmemREN = 1; dmemaddr = 32'h300; smp();
    total++; if (st() !== 5'b10000 || ramaddr !== 32'h200) begin bad++;
      $display("FAIL nopre_hold got=%b/%h exp=%b/%h", st(), ramaddr, 5'b10000, 32'h200); end
    cyc(); ramstate = RS_ACCESS; ramload = 32'hCAFE_0200; smp();
    total++; if (st() !== 5'b10100 || imemload !== 32'hCAFE_0200) begin bad++;
      $display("FAIL nopre_ihit got=%b/%h exp=%b/%h", st(), imemload, 5'b10100, 32'hCAFE_0200); end
    cyc(); imemREN = 0; ramload = 32'hCAFE_0300; smp();
    total++; if (st() !== 5'b00000) begin bad++; $display("FAIL nopre_bubble got=%b exp=%b", st(), 5'b00000); end
    cyc(); smp();
    total++; if (st() !== 5'b10010 || dmemload !== 32'hCAFE_0300 || ramaddr !== 32'h300) begin bad++;
      $display("FAIL nopre_data got=%b/%h/%h exp=%b/%h/%h", st(), dmemload, ramaddr, 5'b10010, 32'hCAFE_0300, 32'h300); end
    cyc(); dmemREN = 0;
  endtask

  task automatic test_abort_and_counters();
    idle_inputs(); cyc();
    dmemREN = 1; dmemaddr = 32'h20; ramstate = RS_BUSY; cyc();
    for (int i = 0; i < 5; i++) cyc();
    dmemREN = 0; ramstate = RS_ACCESS; smp();
    total++; if (st() !== 5'b00000) begin bad++; $display("FAIL abort_nohit got=%b exp=%b", st(), 5'b00000); end
    cyc(); ramstate = RS_FREE; smp();
    total++; if (st() !== 5'b00000) begin bad++; $display("FAIL abort_idle got=%b exp=%b", st(), 5'b00000); end
    // 5 BUSY, ERROR (restarts wait count), 7 BUSY, ACCESS: within limits
    imemREN = 1; imemaddr = 32'h30; ramstate = RS_BUSY; cyc();
    for (int i = 0; i < 5; i++) cyc();
    ramstate = RS_ERROR; cyc();
    ramstate = RS_BUSY;
    for (int i = 0; i < 7; i++) cyc();
    ramstate = RS_ACCESS; ramload = 32'h0000_0030; smp();
    total++; if (st() !== 5'b10100 || imemload !== 32'h30) begin bad++;
      $display("FAIL wait_reset_by_error got=%b/%h exp=%b/%h", st(), imemload, 5'b10100, 32'h30); end
    cyc(); imemREN = 0; cyc();
    // two errors per transaction, twice: retry count must restart per transaction
    for (int t = 0; t < 2; t++) begin
      dmemREN = 1; dmemaddr = 32'h50; ramstate = RS_ERROR; cyc();
      cyc(); cyc();
      ramstate = RS_ACCESS; ramload = 32'h50 + t; smp();
      total++; if (st() !== 5'b10010 || dmemload !== 32'h50 + t) begin bad++;
        $display("FAIL retry_restart_%0d got=%b/%h exp=%b/%h", t, st(), dmemload, 5'b10010, 32'h50 + t); end
      cyc(); dmemREN = 0; ramstate = RS_FREE; cyc();
    end
  endtask

  task automatic test_error_fault();
    idle_inputs(); cyc();
    imemREN = 1; imemaddr = 32'h8; ramstate = RS_ERROR; cyc();
    cyc(); cyc(); smp();                                                // third ERROR cycle
    total++; if (st() !== 5'b10000) begin bad++; $display("FAIL err_third got=%b exp=%b", st(), 5'b10000); end
    cyc(); ramstate = RS_ACCESS; smp();
    total++; if (st() !== 5'b00001) begin bad++; $display("FAIL err_fault got=%b exp=%b", st(), 5'b00001); end
    imemREN = 0; dmemREN = 1; dmemWEN = 1;
    for (int i = 0; i < 3; i++) cyc();
    smp();
    total++; if (st() !== 5'b00001 || dmemload !== 32'h0) begin bad++;
      $display("FAIL err_sticky got=%b/%h exp=%b/0", st(), dmemload, 5'b00001); end
    cyc(); nRST = 0; smp();
    total++; if (st() !== 5'b00000) begin bad++; $display("FAIL err_reset_cycle got=%b exp=%b", st(), 5'b00000); end
    cyc(); nRST = 1; idle_inputs(); smp();
    total++; if (st() !== 5'b00000) begin bad++; $display("FAIL err_cleared got=%b exp=%b", st(), 5'b00000); end
  endtask

  task automatic test_busy_timeout();
    int early;
    early = 0;
    idle_inputs(); cyc();
    imemREN = 1; imemaddr = 32'hC; ramstate = RS_BUSY; cyc();
    for (int i = 0; i < 8; i++) begin
      smp();
      if (st() !== 5'b10000) early++;
      cyc();
    end
    total++; if (early !== 0) begin bad++; $display("FAIL busy_early got=%0d exp=0", early); end
    smp();
    total++; if (st() !== 5'b00001) begin bad++; $display("FAIL busy_fault got=%b exp=%b", st(), 5'b00001); end
    do_reset();
  endtask

  task automatic test_fetch_repeat();
    idle_inputs(); cyc();
    imemREN = 1; imemaddr = 32'h4; ramstate = RS_ACCESS; ramload = 32'hAAAA_0004; cyc(); smp();
    total++; if (st() !== 5'b10100 || imemload !== 32'hAAAA_0004) begin bad++;
      $display("FAIL rep_first got=%b/%h exp=%b/%h", st(), imemload, 5'b10100, 32'hAAAA_0004); end
    cyc(); imemREN = 0; ramstate = RS_FREE; ramload = 32'h0; cyc();
    imemREN = 1; smp();                                                 // second fetch, IDLE
`ifdef MEM_ARB_IBUF_EN
    total++; if (st() !== 5'b00100 || imemload !== 32'hAAAA_0004) begin bad++;
      $display("FAIL ibuf_hit got=%b/%h exp=%b/%h", st(), imemload, 5'b00100, 32'hAAAA_0004); end
    cyc(); imemREN = 0; smp();
    total++; if (st() !== 5'b00000) begin bad++; $display("FAIL ibuf_stay_idle got=%b exp=%b", st(), 5'b00000); end
    dmemWEN = 1; dmemaddr = 32'h4; dmemstore = 32'h1; ramstate = RS_ACCESS; cyc(); smp();
    total++; if (st() !== 5'b01010) begin bad++; $display("FAIL ibuf_store got=%b exp=%b", st(), 5'b01010); end
    cyc(); dmemWEN = 0; ramstate = RS_FREE; cyc();
    imemREN = 1; smp();
    total++; if (st() !== 5'b00000) begin bad++; $display("FAIL ibuf_invalidated got=%b exp=%b", st(), 5'b00000); end
    cyc(); ramstate = RS_ACCESS; ramload = 32'h0000_0001; smp();
    total++; if (st() !== 5'b10100 || imemload !== 32'h1) begin bad++;
      $display("FAIL ibuf_refetch got=%b/%h exp=%b/%h", st(), imemload, 5'b10100, 32'h1); end
`else
    total++; if (st() !== 5'b00000) begin bad++; $display("FAIL rep_no_buffer got=%b exp=%b", st(), 5'b00000); end
    cyc(); smp();
    total++; if (st() !== 5'b10000 || ramaddr !== 32'h4) begin bad++;
      $display("FAIL rep_to_ram got=%b/%h exp=%b/%h", st(), ramaddr, 5'b10000, 32'h4); end
`endif
    cyc(); imemREN = 0; ramstate = RS_FREE; cyc();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fetch_wait();
    test_priority();
    test_store();
    test_no_preempt();
    test_abort_and_counters();
    test_error_fault();
    test_busy_timeout();
    test_fetch_repeat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
